// File: rtl/locker_code_sender.sv
// ============================================================================
// Module   : locker_code_sender
// Brief    : Initiator for the two-step combination lock. It sequences
//            reset/digit strobes, retries on lock error and reports the
//            outcome as ok, fail or timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module locker_code_sender #(
  parameter int MAX_RETRY = 1,
  parameter int TIMEOUT   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic code1,
  input  logic code2,
  input  logic lock_open,
  input  logic lock_error,
  output logic lock_rst,
  output logic comb1,
  output logic comb2,
  output logic enter,
  output logic busy,
  output logic done,
  output logic ok,
  output logic fail,
  output logic tmo
);

  localparam int AW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] c_max_retry = AW'(MAX_RETRY);
  localparam logic [CW-1:0] c_wait_last = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LRST = 3'd1,
    S_E1   = 3'd2,
    S_G1   = 3'd3,
    S_E2   = 3'd4,
    S_G2   = 3'd5,
    S_WAIT = 3'd6,
    S_DONE = 3'd7
  } state_t;

  state_t        r_state;
  logic          r_code1;
  logic          r_code2;
  logic [AW-1:0] r_attempts;
  logic [CW-1:0] r_wcnt;
  logic          r_lock_rst;
  logic          r_comb1;
  logic          r_comb2;
  logic          r_enter;
  logic          r_busy;
  logic          r_done;
  logic          r_ok;
  logic          r_fail;
  logic          r_tmo;

  state_t w_next;
  logic   w_err;
  logic   w_retry;
  logic   w_set_ok;
  logic   w_set_fail;
  logic   w_set_tmo;

  // Error wins over open when both are seen in the same cycle.
  always_comb begin
    w_next    = r_state;
    w_err     = 1'b0;
    w_set_ok  = 1'b0;
    w_set_tmo = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_next = S_LRST;
      S_LRST: w_next = S_E1;
      S_E1:   w_next = S_G1;
      S_G1:   if (lock_error) w_err = 1'b1; else w_next = S_E2;
      S_E2:   if (lock_error) w_err = 1'b1; else w_next = S_G2;
      S_G2: begin
        if (lock_error) begin
          w_err = 1'b1;
        end else if (lock_open) begin
          w_set_ok = 1'b1;
          w_next   = S_DONE;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lock_error) begin
          w_err = 1'b1;
        end else if (lock_open) begin
          w_set_ok = 1'b1;
          w_next   = S_DONE;
        end else if (r_wcnt == c_wait_last) begin
          w_set_tmo = 1'b1;
          w_next    = S_DONE;
        end
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
    w_retry    = w_err && (r_attempts < c_max_retry);
    w_set_fail = w_err && !w_retry;
    if (w_err) w_next = w_retry ? S_LRST : S_DONE;
  end

  // Outputs are decoded from the state being entered so they line up with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_code1    <= 1'b0;
      r_code2    <= 1'b0;
      r_attempts <= '0;
      r_wcnt     <= '0;
      r_lock_rst <= 1'b0;
      r_comb1    <= 1'b0;
      r_comb2    <= 1'b0;
      r_enter    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ok       <= 1'b0;
      r_fail     <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_lock_rst <= (w_next == S_LRST);
      r_comb1    <= (w_next == S_E1) && r_code1;
      r_comb2    <= (w_next == S_E2) && r_code2;
      r_enter    <= (w_next == S_E1) || (w_next == S_E2);
      r_busy     <= (w_next != S_IDLE);
      r_done     <= (w_next == S_DONE);

      if ((r_state == S_WAIT) && (w_next == S_WAIT)) r_wcnt <= r_wcnt + 1'b1;
      else r_wcnt <= '0;

      if ((r_state == S_IDLE) && start) begin
        r_code1    <= code1;
        r_code2    <= code2;
        r_attempts <= '0;
        r_ok       <= 1'b0;
        r_fail     <= 1'b0;
        r_tmo      <= 1'b0;
      end
      if (w_retry)    r_attempts <= r_attempts + 1'b1;
      if (w_set_ok)   r_ok       <= 1'b1;
      if (w_set_fail) r_fail     <= 1'b1;
      if (w_set_tmo)  r_tmo      <= 1'b1;
    end
  end

  assign lock_rst = r_lock_rst;
  assign comb1    = r_comb1;
  assign comb2    = r_comb2;
  assign enter    = r_enter;
  assign busy     = r_busy;
  assign done     = r_done;
  assign ok       = r_ok;
  assign fail     = r_fail;
  assign tmo      = r_tmo;

endmodule

`default_nettype wire

// File: tb/tb_locker_code_sender.sv
// ============================================================================
// Module   : tb_locker_code_sender
// Brief    : Self-checking bench for locker_code_sender with a lock model that
//            answers at chosen cycle offsets within each attempt.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_locker_code_sender;

  localparam int MAX_RETRY = 1;
  localparam int TIMEOUT   = 8;
  localparam int NATT      = MAX_RETRY + 1;
  localparam int LAST_OFF  = 4 + TIMEOUT;
  localparam int NEVER     = 1000;

  logic clk = 1'b0;
  logic reset, start, code1, code2, lock_open, lock_error;
  logic lock_rst, comb1, comb2, enter, busy, done, ok, fail, tmo;

  int checks = 0;
  int errors = 0;
  int err_off  [NATT];
  int open_off [NATT];

  always #5 clk = ~clk;

  locker_code_sender #(.MAX_RETRY(MAX_RETRY), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .start(start), .code1(code1), .code2(code2),
    .lock_open(lock_open), .lock_error(lock_error), .lock_rst(lock_rst),
    .comb1(comb1), .comb2(comb2), .enter(enter), .busy(busy), .done(done),
    .ok(ok), .fail(fail), .tmo(tmo)
  );

  function automatic logic [8:0] outs();
    return {lock_rst, comb1, comb2, enter, busy, done, ok, fail, tmo};
  endfunction

  task automatic check_vec(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b (rst,c1,c2,ent,busy,done,ok,fail,tmo)", tag, obs, exp);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One request: the expected result, attempt count and done cycle come from
  // walking the attempts with offset arithmetic (LRST=0,E1=1,G1=2,E2=3,G2=4,
  // WAIT=5..4+TIMEOUT; errors count from offset 2, opens from offset 4).
  task automatic run_req(input logic c1, input logic c2, input bit hold, input string tag);
    int total = 0;
    int res = -1;
    int nattempt = 0;
    int cyc = 0;
    int att = -1;
    int off = 0;
    int rst_cnt = 0;
    bit seen_done = 1'b0;
    logic [8:0] exp_v;

    for (int a = 0; a < NATT && res < 0; a++) begin
      int te;
      int to;
      te = (err_off[a] >= 2 && err_off[a] <= LAST_OFF) ? err_off[a] : NEVER;
      to = (open_off[a] >= 4 && open_off[a] <= LAST_OFF) ? open_off[a] : NEVER;
      nattempt++;
      if (te != NEVER && te <= to) begin
        total += te + 1;
        if (a == NATT - 1) res = 1;
      end else if (to != NEVER) begin
        total += to + 1;
        res = 0;
      end else begin
        total += LAST_OFF + 1;
        res = 2;
      end
    end

    @(negedge clk);
    code1 = c1;
    code2 = c2;
    start = 1'b1;
    while (!seen_done && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (!hold) start = 1'b0;
      if (hold) begin
        code1 = 1'($urandom);
        code2 = 1'($urandom);
      end
      if (lock_rst) begin
        att++;
        off = 0;
        rst_cnt++;
      end else begin
        off++;
      end
      if (done) begin
        seen_done = 1'b1;
        start = 1'b0;
        exp_v = {6'b000011, res == 0, res == 1, res == 2};
        check_vec({tag, "_done_outs"}, outs(), exp_v);
        check_int({tag, "_done_cycle"}, cyc, total + 1);
        check_int({tag, "_lock_rst_pulses"}, rst_cnt, nattempt);
      end else begin
        exp_v = {off == 0, (off == 1) && c1, (off == 3) && c2,
                 (off == 1) || (off == 3), 1'b1, 4'b0000};
        check_vec({tag, "_seq"}, outs(), exp_v);
      end
      lock_error = (att >= 0 && att < NATT && off == err_off[att]);
      lock_open  = (att >= 0 && att < NATT && off == open_off[att]);
    end
    lock_error = 1'b0;
    lock_open  = 1'b0;
    if (!seen_done) check_int({tag, "_done_seen"}, 0, 1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      exp_v = {6'b000000, res == 0, res == 1, res == 2};
      check_vec({tag, "_idle_hold"}, outs(), exp_v);
    end
  endtask

  task automatic set_resp(input int e0, input int o0, input int e1, input int o1);
    err_off[0]  = e0;
    open_off[0] = o0;
    err_off[1]  = e1;
    open_off[1] = o1;
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; code1 = 1'b0; code2 = 1'b0;
    lock_open = 1'b0; lock_error = 1'b0;
    repeat (2) @(negedge clk);
    check_vec("reset_state", outs(), 9'b0);
    reset = 1'b0;

    set_resp(-1, 4, -1, -1);  run_req(1'b1, 1'b1, 1'b0, "open_first");
    set_resp(4, -1, 4, -1);   run_req(1'b0, 1'b1, 1'b0, "wrong_code");
    set_resp(4, -1, -1, 4);   run_req(1'b1, 1'b0, 1'b0, "retry_open");
    set_resp(-1, -1, -1, -1); run_req(1'b1, 1'b1, 1'b0, "timeout");
    set_resp(-1, 6, -1, -1);  run_req(1'b1, 1'b0, 1'b1, "hold_start");
    set_resp(1, 3, -1, -1);   run_req(1'b0, 1'b0, 1'b0, "early_ignored");
    set_resp(LAST_OFF, -1, -1, LAST_OFF); run_req(1'b1, 1'b1, 1'b0, "last_wait");
    set_resp(5, 5, 2, 2);     run_req(1'b0, 1'b1, 1'b0, "both_high");
    set_resp(3, -1, 12, 12);  run_req(1'b1, 1'b0, 1'b0, "err_e2");

    // Reset asserted while the second digit is being strobed.
    @(negedge clk);
    code1 = 1'b1; code2 = 1'b1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check_vec("pre_reset_e2", outs(), 9'b001110000);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_vec("reset_in_e2", outs(), 9'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_vec("after_reset_idle", outs(), 9'b0);
    end
    set_resp(-1, 4, -1, -1);  run_req(1'b1, 1'b1, 1'b0, "post_reset");

    for (int n = 0; n < 40; n++) begin
      for (int a = 0; a < NATT; a++) begin
        err_off[a]  = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
        open_off[a] = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 15));
      end
      run_req(1'($urandom), 1'($urandom), 1'($urandom_range(0, 1)), "random");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/locker_code_sender.md
Name: locker_code_sender

Overview:
- Initiator side of the locker combination protocol. It drives comb1/comb2/enter into a two-step combination lock and monitors the lock's open/error response.
- It pulses the lock's reset before each attempt and retries a bounded number of times when the lock reports an error.
- It reports a final result to the controlling logic: success, fail or timeout.
- It sits between the system controller and the lock block, so the controller never sequences the keypad protocol itself.

Parameters:
- MAX_RETRY, 1, extra attempts after the first attempt fails with error (0 = single attempt).
- TIMEOUT, 8, cycles to wait in WAIT for open/error before declaring timeout (must be >= 1).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a new unlock attempt; sampled only in IDLE.
- code1  input  1  first combination digit; captured on accepted start.
- code2  input  1  second combination digit; captured on accepted start.
- lock_open  input  1  lock's open output.
- lock_error  input  1  lock's error output.
- lock_rst  output  1  reset pulse to the lock.
- comb1  output  1  first-digit value to the lock.
- comb2  output  1  second-digit value to the lock.
- enter  output  1  digit strobe to the lock.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when a result is final.
- ok  output  1  result flag: lock opened.
- fail  output  1  result flag: error after all retries used.
- tmo  output  1  result flag: timeout.

Behaviour:
- Reset: state=IDLE, attempts=0, wait counter=0. All outputs 0, including ok/fail/tmo.
- Reset has priority over every other input. If it is asserted mid-sequence, the FSM returns to IDLE on the next edge and no done pulse is issued.
- Outputs are registered: each output reflects the current state.
- States:
  - IDLE.
  - LRST: lock_rst=1.
  - E1: comb1=code1_q, enter=1.
  - G1: all lock outputs 0.
  - E2: comb2=code2_q, enter=1.
  - G2: all lock outputs 0.
  - WAIT.
  - DONE: done=1.
- Outputs not listed for a state are 0 in that state.
- IDLE: start=1 captures code1/code2 into code1_q/code2_q, clears ok/fail/tmo and attempts, then goes to LRST.
- start is ignored in every state other than IDLE.
- Fixed sequence: LRST -> E1 -> G1 -> E2 -> G2 -> WAIT, one cycle each. E1 is the 2nd cycle after start is accepted; E2 is the 4th.
- lock_error sampled high in G1, E2, G2 or WAIT ends the current attempt (retry path).
- lock_open is honoured only in G2 and WAIT. If high there and lock_error is low: ok=1, go to DONE.
- lock_open and lock_error both high in the same cycle counts as an error.
- Retry path:
  - If attempts < MAX_RETRY: attempts++, go to LRST. code1_q/code2_q are reused.
  - Otherwise: fail=1, go to DONE.
- WAIT counter:
  - Starts at 0 on entry and increments every WAIT cycle.
  - Reaching TIMEOUT-1 with neither input high sets tmo=1 and goes to DONE.
  - A timeout is never retried.
- DONE: lasts one cycle, then IDLE. ok/fail/tmo hold their value until the next accepted start or reset.
- Exactly one of ok/fail/tmo is set per completed request.
- attempts width is clog2(MAX_RETRY+1), minimum 1. It saturates and never wraps.

Test Plan:
- Correct code, lock opens on first attempt:
  - Stimulus: reset 1 cycle; start with code1=1, code2=1. Lock model asserts lock_open in G2.
  - Required: lock_rst at cycle 1; comb1=1 & enter=1 at cycle 2; comb2=1 & enter=1 at cycle 4; done & ok=1 at cycle 6; lock_rst pulsed exactly once.
- Wrong code with MAX_RETRY=1:
  - Stimulus: lock_error asserted during G2 on every attempt.
  - Required: two lock_rst pulses; done with fail=1, ok=0, tmo=0.
- Error on first attempt, open on second:
  - Required: second sequence repeats the same comb values; done with ok=1.
- No lock response, TIMEOUT=8:
  - Stimulus: lock_open and lock_error held 0.
  - Required: 8 WAIT cycles, then done with tmo=1; no retry (single lock_rst pulse).
- start held high during busy:
  - Required: no restart; exactly one done per request; code change while busy has no effect on comb outputs.
- reset asserted in E2:
  - Required: next cycle IDLE with all outputs 0 and no done. A new start then runs a full clean sequence.
